// File: rtl/i_fetch.sv
// ---------------------------------------------------------------------------
// Purple_Jade_pkg / i_fetch
//
// Purpose
//   Instruction fetch front end. A fetch PC (pc_r) addresses the instruction
//   ROM directly. The ROM returns the word in the same cycle, and that word is
//   captured together with its PC into a 2-entry FIFO. The FIFO head is
//   presented to the consumer with a valid/ready handshake. A redirect flushes
//   the FIFO and reloads pc_r. Reset clears everything.
//
// Ports
//   clk_i          in   1              clock, rising edge
//   reset_i        in   1              synchronous, active-high reset
//   rom_addr_o     out  ADDR_WIDTH_LP  word address to the ROM (= pc_r)
//   rom_data_i     in   WORD_SIZE_P    ROM word for rom_addr_o, same cycle
//   redirect_v_i   in   1              flush the FIFO and refetch from redirect_pc_i
//   redirect_pc_i  in   ADDR_WIDTH_LP  redirect target word address
//   instr_v_o      out  1              FIFO head is valid
//   instr_o        out  WORD_SIZE_P    FIFO head word (0 when the FIFO is empty)
//   instr_pc_o     out  ADDR_WIDTH_LP  FIFO head address (0 when the FIFO is empty)
//   instr_ready_i  in   1              consumer accepts the head this cycle
// ---------------------------------------------------------------------------
package Purple_Jade_pkg;
  localparam int WORD_SIZE_P   = 32;
  // Deliberately not a power of two, so the PC wrap logic is exercised.
  localparam int I_ROM_DEPTH_P = 24;
endpackage

module i_fetch
  import Purple_Jade_pkg::*;
(
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  output logic [$clog2(I_ROM_DEPTH_P)-1:0]       rom_addr_o,
  input  logic [WORD_SIZE_P-1:0]                 rom_data_i,
  input  logic                                   redirect_v_i,
  input  logic [$clog2(I_ROM_DEPTH_P)-1:0]       redirect_pc_i,
  output logic                                   instr_v_o,
  output logic [WORD_SIZE_P-1:0]                 instr_o,
  output logic [$clog2(I_ROM_DEPTH_P)-1:0]       instr_pc_o,
  input  logic                                   instr_ready_i
);

  localparam int ADDR_WIDTH_LP = $clog2(I_ROM_DEPTH_P);
  localparam logic [ADDR_WIDTH_LP-1:0] LAST_PC_LP = ADDR_WIDTH_LP'(I_ROM_DEPTH_P - 1);

  logic [ADDR_WIDTH_LP-1:0] pc_r;
  logic [ADDR_WIDTH_LP-1:0] pc_next;

  logic [ADDR_WIDTH_LP-1:0] fifo_pc_r   [2];
  logic [WORD_SIZE_P-1:0]   fifo_word_r [2];
  logic                     head_r;
  logic [1:0]               count_r;

  logic                     tail;
  logic                     deq;
  logic                     enq;

  // With two slots the tail is head + count (mod 2). When the FIFO is full
  // and a dequeue happens, this selects the slot being vacated. That is safe
  // because the head moves past it on the same edge.
  assign tail = head_r ^ count_r[0];

  assign instr_v_o  = (count_r != 2'd0);
  assign instr_o    = instr_v_o ? fifo_word_r[head_r] : '0;
  assign instr_pc_o = instr_v_o ? fifo_pc_r[head_r]   : '0;

  assign rom_addr_o = pc_r;

  assign deq = instr_v_o & instr_ready_i;
  assign enq = ~redirect_v_i & ((count_r < 2'd2) | deq);

  // Explicit wrap: an increment modulo 2^ADDR_WIDTH_LP would be wrong for
  // depths that are not a power of two.
  assign pc_next = (pc_r == LAST_PC_LP) ? '0 : pc_r + 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_r    <= '0;
      head_r  <= 1'b0;
      count_r <= 2'd0;
    end else if (redirect_v_i) begin
      // A deq in this cycle has already been accepted by the consumer.
      // Everything still queued is dropped.
      pc_r    <= redirect_pc_i;
      head_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) begin
        fifo_pc_r[tail]   <= pc_r;
        fifo_word_r[tail] <= rom_data_i;
        pc_r              <= pc_next;
      end
      if (deq) begin
        head_r <= ~head_r;
      end
      case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_i_fetch.sv
// ---------------------------------------------------------------------------
// tb_i_fetch
//
// Purpose
//   Directed bench for i_fetch. Covers the following:
//     - reset state
//     - streaming
//     - backpressure
//     - redirect from a full FIFO
//     - PC wrap on a non-power-of-two depth
//     - redirect together with a dequeue
//     - reset together with a redirect
//   The ROM is a pure function of the address, and the bench uses the same
//   function to compute expected instruction words.
//
// Ports
//   none (top-level bench)
// ---------------------------------------------------------------------------
module tb_i_fetch;
  import Purple_Jade_pkg::*;

  localparam int AW = $clog2(I_ROM_DEPTH_P);

  logic                   clk_i = 1'b0;
  logic                   reset_i;
  logic [AW-1:0]          rom_addr_o;
  logic [WORD_SIZE_P-1:0] rom_data_i;
  logic                   redirect_v_i;
  logic [AW-1:0]          redirect_pc_i;
  logic                   instr_v_o;
  logic [WORD_SIZE_P-1:0] instr_o;
  logic [AW-1:0]          instr_pc_o;
  logic                   instr_ready_i;

  int checks   = 0;
  int failures = 0;

  i_fetch dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .redirect_v_i  (redirect_v_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_v_o     (instr_v_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return 32'hC0DE_0000 | a32 | (a32 << 8);
  endfunction

  assign rom_data_i = rom_word(rom_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: the rising edge happens, then the bench samples at the next
  // falling edge.
  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic check_head(input string tag, input int pc);
    check({tag, ".v"},     32'(instr_v_o),  32'd1);
    check({tag, ".pc"},    32'(instr_pc_o), 32'(pc));
    check({tag, ".instr"}, instr_o,         rom_word(AW'(pc)));
  endtask

  initial begin
    reset_i       = 1'b1;
    redirect_v_i  = 1'b1;
    redirect_pc_i = AW'(9);
    instr_ready_i = 1'b1;
    cyc();
    cyc();
    check("rst.v",     32'(instr_v_o),  32'd0);
    check("rst.instr", instr_o,         32'd0);
    check("rst.pc",    32'(instr_pc_o), 32'd0);
    check("rst.addr",  32'(rom_addr_o), 32'd0);

    // Streaming after reset: pcs 0,1,2,... on consecutive cycles.
    reset_i      = 1'b0;
    redirect_v_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check_head("stream", i);
    end

    // Backpressure: ready held low for 5 cycles after the first valid.
    reset_i = 1'b1;
    cyc();
    reset_i       = 1'b0;
    instr_ready_i = 1'b0;
    cyc();
    check_head("bp.first", 0);
    for (int i = 0; i < 5; i++) cyc();
    check("bp.addr_hold", 32'(rom_addr_o), 32'd2);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_head("bp.drain", i);
      cyc();
    end

    // Fill the FIFO, then redirect to 0x10.
    instr_ready_i = 1'b0;
    cyc();
    cyc();
    redirect_v_i  = 1'b1;
    redirect_pc_i = AW'(16);
    cyc();
    check("redir.v",     32'(instr_v_o),  32'd0);
    check("redir.addr",  32'(rom_addr_o), 32'h10);
    check("redir.pc0",   32'(instr_pc_o), 32'd0);
    check("redir.instr", instr_o,         32'd0);
    redirect_v_i  = 1'b0;
    instr_ready_i = 1'b1;
    cyc();
    check_head("redir.t0", 16);
    cyc();
    check_head("redir.t1", 17);

    // Redirect to the last ROM word; the PC must wrap to 0.
    redirect_v_i  = 1'b1;
    redirect_pc_i = AW'(I_ROM_DEPTH_P - 1);
    cyc();
    check("wrap.v",    32'(instr_v_o),  32'd0);
    check("wrap.addr", 32'(rom_addr_o), 32'(I_ROM_DEPTH_P - 1));
    redirect_v_i = 1'b0;
    cyc();
    check_head("wrap.last", I_ROM_DEPTH_P - 1);
    cyc();
    check_head("wrap.zero", 0);
    cyc();
    check_head("wrap.one", 1);

    // Fill the FIFO (head pc 1, second entry pc 2). Then redirect in the
    // same cycle as a dequeue. Entry pc 2 must never appear.
    instr_ready_i = 1'b0;
    cyc();
    cyc();
    check_head("rdq.head", 1);
    check("rdq.addr", 32'(rom_addr_o), 32'd3);
    redirect_v_i  = 1'b1;
    redirect_pc_i = AW'(5);
    instr_ready_i = 1'b1;
    cyc();
    check("rdq.v", 32'(instr_v_o), 32'd0);
    redirect_v_i = 1'b0;
    cyc();
    check_head("rdq.t0", 5);
    cyc();
    check_head("rdq.t1", 6);

    // Reset and redirect together with the FIFO full: reset wins.
    instr_ready_i = 1'b0;
    cyc();
    cyc();
    reset_i       = 1'b1;
    redirect_v_i  = 1'b1;
    redirect_pc_i = AW'(7);
    cyc();
    check("rr.addr", 32'(rom_addr_o), 32'd0);
    check("rr.v",    32'(instr_v_o),  32'd0);
    reset_i       = 1'b0;
    redirect_v_i  = 1'b0;
    instr_ready_i = 1'b1;
    cyc();
    check_head("rr.first", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
